// File: rtl/stream_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_arb_pkg
// Description : Shared types, defaults and helpers for the stream arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_arb_pkg;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_LOCK_PKT   = 1;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_pick
// Description : Combinational round-robin picker. Rotates the request vector
//               so that index ptr lands at bit 0, priority-encodes the lowest
//               set bit and translates the offset back to a requester index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_pick
    import stream_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ID_W    = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic               any_o,
    output logic [ID_W-1:0]    grant_idx_o
);

    localparam int unsigned DBL_W = 2 * NUM_REQ - 1;
    localparam int unsigned BASE_W = $clog2(DBL_W);
    localparam int unsigned SUM_W = ID_W + 1;

    logic [DBL_W-1:0]   w_dbl;
    logic [BASE_W-1:0]  w_base;
    logic [NUM_REQ-1:0] w_rot;
    logic [ID_W-1:0]    w_off;
    logic               w_found;
    logic [SUM_W-1:0]   w_sum;

    // Rotate by ptr, find the first requester at or after ptr, wrap the index.
    always_comb begin
        // The top copy only needs NUM_REQ-1 bits: the window never reaches
        // past ptr + NUM_REQ - 1.
        w_dbl   = {req_i[NUM_REQ-2:0], req_i};
        w_base  = BASE_W'(ptr_i);
        w_rot   = w_dbl[w_base +: NUM_REQ];
        w_off   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_off   = ID_W'(k);
            end
        end
        w_sum = SUM_W'(ptr_i) + SUM_W'(w_off);
        if (w_sum >= SUM_W'(NUM_REQ)) begin
            w_sum = w_sum - SUM_W'(NUM_REQ);
        end
        grant_idx_o = w_sum[ID_W-1:0];
        any_o       = |req_i;
    end

endmodule
`default_nettype wire

// File: rtl/stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : stream_rr_arbiter
// Description : Round-robin arbiter sharing one registered valid/ready output
//               stage between NUM_REQ streams, with optional packet locking
//               so multi-beat packets are never interleaved.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned LOCK_PKT   = DEF_LOCK_PKT,
    parameter int unsigned ID_W       = idx_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DATA_WIDTH-1:0]         out_data_o,
    output logic                          out_last_o,
    output logic [ID_W-1:0]               out_id_o
);

    arb_state_e            state_q, state_d;
    logic [ID_W-1:0]       lock_id_q, lock_id_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic                  full_q, full_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic [ID_W-1:0]       id_q, id_d;

    logic                  w_pick_any;
    logic [ID_W-1:0]       w_pick_idx;
    logic                  w_stage_ready;
    logic                  w_cand;
    logic [ID_W-1:0]       w_grant;
    logic [ID_W-1:0]       w_grant_nxt;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_last;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_i       (req_valid_i),
        .ptr_i       (ptr_q),
        .any_o       (w_pick_any),
        .grant_idx_o (w_pick_idx)
    );

    // Grant selection: the locked requester is the sole candidate mid-packet.
    always_comb begin
        w_stage_ready = !full_q || out_ready_i;
        if (state_q == LOCK) begin
            w_grant = lock_id_q;
            w_cand  = req_valid_i[lock_id_q];
        end else begin
            w_grant = w_pick_idx;
            w_cand  = w_pick_any;
        end
        w_accept   = w_cand && w_stage_ready && !rst;
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_o[i] = w_accept && (w_grant == ID_W'(i));
            if (w_grant == ID_W'(i)) begin
                w_sel_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_last = req_last_i[i];
            end
        end
        w_grant_nxt = (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + ID_W'(1);
    end

    // Next state for the output stage, lock FSM and round-robin pointer.
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        ptr_d     = ptr_q;
        full_d    = full_q;
        data_d    = data_q;
        last_d    = last_q;
        id_d      = id_q;

        if (full_q && out_ready_i) begin
            full_d = 1'b0;
        end

        // An accept in the same cycle as an output handshake overwrites the
        // stage, so throughput stays at one beat per cycle.
        if (w_accept) begin
            full_d = 1'b1;
            data_d = w_sel_data;
            last_d = w_sel_last;
            id_d   = w_grant;
            if (LOCK_PKT != 0) begin
                if (w_sel_last) begin
                    state_d = ARB;
                    ptr_d   = w_grant_nxt;
                end else begin
                    state_d   = LOCK;
                    lock_id_d = w_grant;
                end
            end else begin
                ptr_d = w_grant_nxt;
            end
        end
    end

    // State registers; reset drops any held beat and any packet lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB;
            lock_id_q <= '0;
            ptr_q     <= '0;
            full_q    <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            ptr_q     <= ptr_d;
            full_q    <= full_d;
            data_q    <= data_d;
            last_q    <= last_d;
            id_q      <= id_d;
        end
    end

    assign out_valid_o = full_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;
    assign out_id_o    = id_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_rr_arbiter
// Description : Self-checking bench for stream_rr_arbiter. Per-requester
//               source queues feed the DUT; expected beats are queued in
//               predicted arbitration order and popped on output handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_rr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int IDW  = 2;
    localparam int SRCD = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]    req_last = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [DW-1:0]      out_data;
    logic               out_last;
    logic [IDW-1:0]     out_id;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        logic           last;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;

    logic [DW-1:0] sdata [NREQ][SRCD];
    logic          slast [NREQ][SRCD];
    logic          sbub  [NREQ][SRCD];
    int            wr [NREQ];
    int            rd [NREQ];
    logic [NREQ-1:0] hs = '0;

    stream_rr_arbiter #(
        .NUM_REQ    (NREQ),
        .DATA_WIDTH (DW),
        .LOCK_PKT   (1),
        .ID_W       (IDW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_id_o    (out_id)
    );

    always #5 clk = ~clk;

    // Source driver: advance past accepted beats, present the next head.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) rd[i] = rd[i] + 1;
            if (rd[i] < wr[i]) begin
                if (sbub[i][rd[i]]) begin
                    sbub[i][rd[i]] = 1'b0;
                    req_valid[i]   = 1'b0;
                end else begin
                    req_valid[i]           = 1'b1;
                    req_data[i*DW +: DW]   = sdata[i][rd[i]];
                    req_last[i]            = slast[i][rd[i]];
                end
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    end

    // Monitor: record input handshakes and score output handshakes.
    always @(negedge clk) begin
        hs = req_valid & req_ready;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got id=%0d data=%h last=%b, required no beat",
                         out_id, out_data, out_last);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_id !== mon_e.id || out_data !== mon_e.data || out_last !== mon_e.last) begin
                    errors++;
                    $display("FAIL beat: got id=%0d data=%h last=%b, required id=%0d data=%h last=%b",
                             out_id, out_data, out_last, mon_e.id, mon_e.data, mon_e.last);
                end
            end
        end
    end

    task automatic src_add(input int i, input logic [DW-1:0] d, input logic l, input logic b);
        sdata[i][wr[i]] = d;
        slast[i][wr[i]] = l;
        sbub[i][wr[i]]  = b;
        wr[i]           = wr[i] + 1;
    endtask

    task automatic exp_add(input int id, input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.id   = IDW'(id);
        b.data = d;
        b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || req_ready !== 4'b0000 || out_id !== 2'd0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b ready=%b id=%0d data=%h, required 0 0000 0 0",
                     out_valid, req_ready, out_id, out_data);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL idle: got valid=%b ready=%b, required 0 0000", out_valid, req_ready);
        end
    endtask

    task automatic test_fairness;
        int n;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NREQ; i++) begin
                src_add(i, 32'h100 * i + k, 1'b1, 1'b0);
                exp_add(i, 32'h100 * i + k, 1'b1);
            end
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL fair_throughput: beat %0d got valid=%b, required 1", k, out_valid);
            end
            @(negedge clk);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL fair_drain: got %0d beats pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_packet_lock;
        int n;
        @(posedge clk); #1;
        src_add(0, 32'hA0, 1'b0, 1'b0);
        src_add(0, 32'hA1, 1'b0, 1'b1);
        src_add(0, 32'hA2, 1'b1, 1'b0);
        src_add(1, 32'hB0, 1'b1, 1'b0);
        exp_add(0, 32'hA0, 1'b0);
        exp_add(0, 32'hA1, 1'b0);
        exp_add(0, 32'hA2, 1'b1);
        exp_add(1, 32'hB0, 1'b1);
        n = 0;
        @(negedge clk);
        while (rd[0] < wr[0] && n < 30) begin
            checks++;
            if (req_ready[1] !== 1'b0) begin
                errors++;
                $display("FAIL lock_hold: cycle %0d got ready=%b, required ready[1]=0", n, req_ready);
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (rd[0] < wr[0]) begin
            errors++;
            $display("FAIL lock_timeout: got %0d of %0d req0 beats accepted, required all", rd[0], wr[0]);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL lock_drain: got %0d beats pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure;
        int n;
        @(posedge clk); #1;
        out_ready = 1'b0;
        src_add(0, 32'h11, 1'b1, 1'b0);
        src_add(0, 32'h22, 1'b1, 1'b0);
        exp_add(0, 32'h11, 1'b1);
        exp_add(0, 32'h22, 1'b1);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h11 || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold: stall %0d got valid=%b data=%h ready=%b, required 1 00000011 0000",
                         k, out_valid, out_data, req_ready);
            end
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h22) begin
            errors++;
            $display("FAIL bp_release: got valid=%b data=%h, required 1 00000022", out_valid, out_data);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: got %0d beats pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        int n;
        @(posedge clk); #1;
        src_add(1, 32'h55, 1'b1, 1'b0);
        src_add(2, 32'hBEEF, 1'b1, 1'b0);
        exp_add(1, 32'h55, 1'b1);
        exp_add(2, 32'hBEEF, 1'b1);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hBEEF || out_id !== 2'd2) begin
            errors++;
            $display("FAIL b2b: got valid=%b data=%h id=%0d, required 1 0000beef 2",
                     out_valid, out_data, out_id);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: got %0d beats pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_packet;
        int n;
        @(posedge clk); #1;
        out_ready = 1'b0;
        src_add(3, 32'hA5, 1'b0, 1'b0);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd3) begin
            errors++;
            $display("FAIL mid_first_beat: got valid=%b id=%0d, required 1 3", out_valid, out_id);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_id !== 2'd0 || out_data !== 32'h0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b id=%0d data=%h last=%b, required 0 0 0 0",
                     out_valid, out_id, out_data, out_last);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        src_add(1, 32'hC1, 1'b1, 1'b0);
        src_add(2, 32'hC2, 1'b1, 1'b0);
        src_add(3, 32'hC3, 1'b1, 1'b0);
        exp_add(1, 32'hC1, 1'b1);
        exp_add(2, 32'hC2, 1'b1);
        exp_add(3, 32'hC3, 1'b1);
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_drain: got %0d beats pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            wr[i] = 0;
            rd[i] = 0;
        end
        test_reset();
        test_fairness();
        test_packet_lock();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_packet();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
